// File: rtl/pcpu_bus_pkg.sv
// Shared encodings and default widths for the MIO bus arbiter.
package pcpu_bus_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_IF_BUSY  = 2'b01,
        ST_MEM_BUSY = 2'b10
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/mio_wait_timer.sv
// Wait-state counter for one bus transaction. The expired flag is registered
// and rises in the BUSY cycle whose missing ready would make TIMEOUT cycles.
module mio_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned     TMO   = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int unsigned     CNT_W = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TMO - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and saturate at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and look-ahead expiry flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_o <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_o <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/mio_arbiter.sv
// Arbiter between the fetch port and the data port on the shared MIO bus.
// One transaction at a time, round-robin on contention, timeout abort.
module mio_arbiter
    import pcpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    input  logic              MIO_ready,
    input  logic [DATA_W-1:0] Data_in,
    output logic [ADDR_W-1:0] Addr_out,
    output logic [DATA_W-1:0] Data_out,
    output logic              mem_w,
    output logic              CPU_MIO,
    output logic              bus_err,
    output logic [1:0]        state
);

    state_e            state_q;
    grant_e            last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_w_q;
    logic              cpu_mio_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_done_q;
    logic              mem_done_q;
    logic              bus_err_q;

    logic if_eff_c;
    logic mem_eff_c;
    logic gnt_if_c;
    logic gnt_mem_c;
    logic tmr_clear_c;
    logic tmr_en_c;
    logic expired;

    // Grant decision in IDLE; a port finishing this cycle is not re-granted.
    always_comb begin
        if_eff_c  = if_req  && !if_done_q;
        mem_eff_c = mem_req && !mem_done_q;
        gnt_if_c  = 1'b0;
        gnt_mem_c = 1'b0;
        if (state_q == ST_IDLE) begin
            if (if_eff_c && mem_eff_c) begin
                if (last_grant_q == GNT_IF) begin
                    gnt_mem_c = 1'b1;
                end else begin
                    gnt_if_c = 1'b1;
                end
            end else begin
                gnt_if_c  = if_eff_c;
                gnt_mem_c = mem_eff_c;
            end
        end
    end

    // Timer counts BUSY cycles without ready and is held clear in IDLE.
    always_comb begin
        tmr_clear_c = (state_q == ST_IDLE);
        tmr_en_c    = (state_q != ST_IDLE) && !MIO_ready;
    end

    mio_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (reset),
        .clear_i   (tmr_clear_c),
        .en_i      (tmr_en_c),
        .expired_o (expired)
    );

    // Arbitration FSM with registered bus and requester outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_w_q      <= 1'b0;
            cpu_mio_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_mem_c) begin
                        state_q      <= ST_MEM_BUSY;
                        last_grant_q <= GNT_MEM;
                        addr_q       <= mem_addr;
                        cpu_mio_q    <= 1'b1;
                        mem_w_q      <= mem_we;
                        wdata_q      <= mem_we ? mem_wdata : '0;
                    end else if (gnt_if_c) begin
                        state_q      <= ST_IF_BUSY;
                        last_grant_q <= GNT_IF;
                        addr_q       <= if_addr;
                        cpu_mio_q    <= 1'b1;
                        mem_w_q      <= 1'b0;
                        wdata_q      <= '0;
                    end
                end
                ST_IF_BUSY, ST_MEM_BUSY: begin
                    if (MIO_ready || expired) begin
                        state_q   <= ST_IDLE;
                        addr_q    <= '0;
                        wdata_q   <= '0;
                        mem_w_q   <= 1'b0;
                        cpu_mio_q <= 1'b0;
                        bus_err_q <= !MIO_ready;
                        if (state_q == ST_IF_BUSY) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= MIO_ready ? Data_in : '0;
                        end else begin
                            mem_done_q <= 1'b1;
                            if (!MIO_ready) begin
                                mem_rdata_q <= '0;
                            end else if (!mem_w_q) begin
                                mem_rdata_q <= Data_in;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign Addr_out  = addr_q;
    assign Data_out  = wdata_q;
    assign mem_w     = mem_w_q;
    assign CPU_MIO   = cpu_mio_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Scoreboard bench for mio_arbiter: directed stimulus pushes expected grants
// and completions; negedge monitors pop and compare as the DUT presents them.
module tb_mio_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        MIO_ready;
    logic [31:0] Data_in;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        mem_w;
    logic        CPU_MIO;
    logic        bus_err;
    logic [1:0]  state;

    mio_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .MIO_ready (MIO_ready),
        .Data_in   (Data_in),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .mem_w     (mem_w),
        .CPU_MIO   (CPU_MIO),
        .bus_err   (bus_err),
        .state     (state)
    );

    typedef struct {
        logic [1:0]  st;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } gnt_t;

    typedef struct {
        logic        port;   // 0 = IF, 1 = MEM
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t cur;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [1:0] prev_state = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic evt_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_gnt(input logic [1:0] st, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input int c);
        gnt_t g;
        g.st = st; g.addr = a; g.we = we; g.wdata = wd; g.cyc = c;
        gq.push_back(g);
    endtask

    task automatic push_rsp(input logic port, input logic [31:0] rd, input logic err, input int c);
        rsp_t r;
        r.port = port; r.rdata = rd; r.err = err; r.cyc = c;
        rq.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Bus-side monitor: new grants, held bus values while BUSY, cleared bus in IDLE.
    always @(negedge clk) begin
        if (state != 2'b00 && prev_state == 2'b00) begin
            if (gq.size() == 0) begin
                evt_fail("unexpected_grant");
            end else begin
                cur = gq.pop_front();
                chk("grant_cycle", 64'(cyc), 64'(cur.cyc));
                chk("grant_state", 64'(state), 64'(cur.st));
            end
        end
        if (state != 2'b00) begin
            chk("busy_addr",    64'(Addr_out), 64'(cur.addr));
            chk("busy_mem_w",   64'(mem_w),    64'(cur.we));
            chk("busy_wdata",   64'(Data_out), 64'(cur.wdata));
            chk("busy_cpu_mio", 64'(CPU_MIO),  64'd1);
        end else begin
            chk("idle_bus", 64'({Addr_out, Data_out, mem_w, CPU_MIO}), 64'd0);
        end
        prev_state = state;
    end

    // Completion monitor: each done pulse consumes one expected response.
    always @(negedge clk) begin
        rsp_t r;
        if (if_done && mem_done) begin
            evt_fail("double_done");
        end else if (if_done || mem_done) begin
            if (rq.size() == 0) begin
                evt_fail("unexpected_done");
            end else begin
                r = rq.pop_front();
                chk("done_port",  64'(mem_done), 64'(r.port));
                chk("done_cycle", 64'(cyc), 64'(r.cyc));
                chk("done_err",   64'(bus_err), 64'(r.err));
                chk("done_state", 64'(state), 64'd0);
                chk("done_rdata", 64'(mem_done ? mem_rdata : if_rdata), 64'(r.rdata));
            end
        end else if (bus_err) begin
            evt_fail("bus_err_without_done");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        MIO_ready = 1'b0;
        Data_in   = '0;
        repeat (3) tick();
        chk("reset_outputs", 64'({if_done, mem_done, bus_err, state, CPU_MIO, mem_w}), 64'd0);
        chk("reset_rdata",   64'({if_rdata, mem_rdata}), 64'd0);
        reset = 1'b0;
        tick();

        // Fetch only, ready in cycle 1.
        b = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        push_gnt(2'b01, 32'h40, 1'b0, 32'h0, b + 1);
        push_rsp(1'b0, 32'h2002_0005, 1'b0, b + 2);
        tick();
        MIO_ready = 1'b1; Data_in = 32'h2002_0005;
        tick();
        MIO_ready = 1'b0; Data_in = '0; if_req = 1'b0;
        repeat (2) tick();

        // Simultaneous after reset: MEM write wins, then IF.
        do_reset();
        tick();
        b = cyc;
        if_req = 1'b1; if_addr = 32'h44;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h0000_CAFE;
        MIO_ready = 1'b1; Data_in = 32'h1111_0000;
        push_gnt(2'b10, 32'h100, 1'b1, 32'hCAFE, b + 1);
        push_rsp(1'b1, 32'h0, 1'b0, b + 2);
        push_gnt(2'b01, 32'h44, 1'b0, 32'h0, b + 3);
        push_rsp(1'b0, 32'h1111_0000, 1'b0, b + 4);
        repeat (2) tick();
        mem_req = 1'b0; mem_we = 1'b0;
        repeat (2) tick();
        if_req = 1'b0; MIO_ready = 1'b0;
        repeat (2) tick();

        // MEM read with three wait states.
        b = cyc;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
        push_gnt(2'b10, 32'h200, 1'b0, 32'h0, b + 1);
        push_rsp(1'b1, 32'hDEAD_BEEF, 1'b0, b + 5);
        for (int k = 1; k <= 3; k++) begin
            tick();
            Data_in = 32'hAAAA_0000 + 32'(k);
        end
        tick();
        MIO_ready = 1'b1; Data_in = 32'hDEAD_BEEF;
        tick();
        MIO_ready = 1'b0; mem_req = 1'b0; Data_in = '0;
        repeat (2) tick();

        // Timeout (TIMEOUT = 8): fetch never acknowledged.
        b = cyc;
        if_req = 1'b1; if_addr = 32'h80;
        push_gnt(2'b01, 32'h80, 1'b0, 32'h0, b + 1);
        push_rsp(1'b0, 32'h0, 1'b1, b + 9);
        repeat (9) tick();
        if_req = 1'b0;
        repeat (2) tick();

        // Ready arrives in the last allowed cycle: normal completion.
        b = cyc;
        if_req = 1'b1; if_addr = 32'h84;
        push_gnt(2'b01, 32'h84, 1'b0, 32'h0, b + 1);
        push_rsp(1'b0, 32'h0BAD_F00D, 1'b0, b + 9);
        repeat (8) tick();
        MIO_ready = 1'b1; Data_in = 32'h0BAD_F00D;
        tick();
        MIO_ready = 1'b0; Data_in = '0; if_req = 1'b0;
        repeat (2) tick();

        // Both held continuously after reset: MEM, IF, MEM, IF.
        do_reset();
        tick();
        b = cyc;
        if_req = 1'b1; if_addr = 32'h48;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
        MIO_ready = 1'b1; Data_in = 32'h5A5A_0000;
        for (int k = 0; k < 2; k++) begin
            push_gnt(2'b10, 32'h300, 1'b0, 32'h0, b + 4 * k + 1);
            push_rsp(1'b1, 32'h5A5A_0000, 1'b0, b + 4 * k + 2);
            push_gnt(2'b01, 32'h48, 1'b0, 32'h0, b + 4 * k + 3);
            push_rsp(1'b0, 32'h5A5A_0000, 1'b0, b + 4 * k + 4);
        end
        repeat (8) tick();
        if_req = 1'b0; mem_req = 1'b0; MIO_ready = 1'b0; Data_in = '0;
        repeat (2) tick();

        // Async reset in the middle of a MEM read, then re-issue.
        b = cyc;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
        push_gnt(2'b10, 32'h400, 1'b0, 32'h0, b + 1);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_bus",   64'({Addr_out, mem_w, CPU_MIO}), 64'd0);
        chk("async_rst_state", 64'({state, mem_done, if_done, bus_err}), 64'd0);
        chk("async_rst_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
        tick();
        reset = 1'b0;
        b = cyc;
        MIO_ready = 1'b1; Data_in = 32'h600D_0400;
        push_gnt(2'b10, 32'h400, 1'b0, 32'h0, b + 1);
        push_rsp(1'b1, 32'h600D_0400, 1'b0, b + 2);
        repeat (2) tick();
        mem_req = 1'b0; MIO_ready = 1'b0; Data_in = '0;

        // Drain: every expected grant and completion must have been seen.
        for (int k = 0; k < 20 && (gq.size() != 0 || rq.size() != 0); k++) tick();
        repeat (2) tick();
        chk("grants_pending",    64'(gq.size()), 64'd0);
        chk("responses_pending", 64'(rq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Bus arbiter between the pipeline's instruction-fetch port and data-memory port, sharing the single MIO bus (`Addr_out`/`Data_out`/`Data_in`/`mem_w`/`CPU_MIO`/`MIO_ready`) that the CPU top exposes. It runs one transaction at a time through a three-state FSM, absorbs `MIO_ready` wait states, and aborts hung transactions with a bus-error pulse. It sits between the IF/MEM pipeline stages and the CPU-top bus pins; the pipeline stalls while its port's request is pending.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: BUSY cycles without `MIO_ready` before abort; must be ≥1.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request, level, held until `if_done`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word.
- `if_done`  out  1  one-cycle completion pulse.
- `mem_req`  in  1  data request, level, held until `mem_done`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  ADDR_W  data address.
- `mem_wdata`  in  DATA_W  write data.
- `mem_rdata`  out  DATA_W  read data.
- `mem_done`  out  1  one-cycle completion pulse.
- `MIO_ready`  in  1  bus completes current access.
- `Data_in`  in  DATA_W  bus read data.
- `Addr_out`  out  ADDR_W  bus address.
- `Data_out`  out  DATA_W  bus write data.
- `mem_w`  out  1  bus write strobe.
- `CPU_MIO`  out  1  bus transaction active.
- `bus_err`  out  1  one-cycle pulse, coincident with the aborted port's `done`.
- `state`  out  2  FSM state (debug).

## Operation
- States: IDLE, IF_BUSY, MEM_BUSY.
- IDLE: effective requests are `if_req` and `mem_req`, with the port whose `done` is high this cycle masked. If only one is present, grant it. If both are present, grant the port not granted last (`last_grant` register, resets to IF, so MEM wins first). No request: stay in IDLE.
- On grant, register the bus outputs: `Addr_out` ← port address; `CPU_MIO` ← 1. For a MEM write, `mem_w` ← 1 and `Data_out` ← `mem_wdata`; otherwise both are 0. Clear the wait counter.
- BUSY: bus outputs hold constant. Each edge with `MIO_ready`=1:
  - Reads capture `Data_in` into the owner's rdata register.
  - Go to IDLE; clear bus outputs to 0; pulse the owner's `done` next cycle.
- BUSY without `MIO_ready`: counter increments. When it reaches TIMEOUT, abort:
  - Go to IDLE; clear bus outputs.
  - Owner's `done` and `bus_err` pulse together.
  - Owner's rdata ← 0.
- The rdata registers hold until that port's next completion.
- Requester inputs are sampled only at grant. Changes during BUSY are ignored.
- Reset (any time, including mid-BUSY): IDLE, `last_grant`=IF, counter 0.
  - All outputs go to 0 immediately: `Addr_out`, `Data_out`, `mem_w`, `CPU_MIO`, both rdata, both `done`, `bus_err`, `state`=IDLE.
  - No `done` is issued for the killed transaction; requesters re-issue.

## Timing
- Request seen in IDLE at cycle 0 → BUSY with bus driven in cycle 1.
- With `MIO_ready`=1 in cycle 1 → `done` (and rdata valid) in cycle 2. Minimum latency is 2 cycles.
- Each wait-state cycle adds 1 cycle.
- Timeout: BUSY cycles 1..TIMEOUT → `done`+`bus_err` in cycle TIMEOUT+1.
- Back-to-back: a `done` cycle is an IDLE cycle, so the other port may be granted in it. Steady-state throughput is one transaction per 2 cycles.
- Counter width: $clog2(TIMEOUT+1). It saturates at TIMEOUT and never wraps.
- `MIO_ready` sampled in IDLE is ignored.

## Structure
- Shared package `pcpu_bus_pkg`:
  - State encoding: IDLE=2'b00, IF_BUSY=2'b01, MEM_BUSY=2'b10.
  - Grant encoding: GNT_IF=0, GNT_MEM=1.
  - Default widths.
- One sub-module, `mio_wait_timer`: clear/enable counter with a TIMEOUT parameter and an `expired` output.

## Test plan
- Fetch only: `if_addr`=0x00000040; `MIO_ready`=1 and `Data_in`=0x20020005 in cycle 1 → `CPU_MIO`=1, `Addr_out`=0x40 in cycle 1; `if_done`=1 and `if_rdata`=0x20020005 in cycle 2; bus outputs back to 0.
- Simultaneous after reset: MEM write to 0x100 with data 0x0000CAFE, plus fetch from 0x44, `MIO_ready` always 1:
  - MEM granted first: `mem_w`=1, `Data_out`=0xCAFE in cycle 1; `mem_done` in cycle 2.
  - IF granted in cycle 2; `if_done` in cycle 4.
- Wait states: MEM read at 0x200, `MIO_ready` low for cycles 1–3 and high in cycle 4 → `Addr_out` stable 0x200 in cycles 1–4; `mem_done` in cycle 5 with `mem_rdata`=`Data_in` of cycle 4.
- Timeout with TIMEOUT=8: fetch, `MIO_ready` never asserted → `if_done` and `bus_err` in cycle 9; `if_rdata`=0; FSM IDLE.
- Both requests held continuously with `MIO_ready`=1 → grant order MEM, IF, MEM, IF; no duplicate grant in any `done` cycle.
- Async reset asserted mid-MEM_BUSY, between clock edges → all outputs 0 before the next edge; no `mem_done`; after release, a re-issued request completes normally.
